// File: rtl/codificador_siete_segmentos_pkg.sv
// Purpose : shared constants for the seven-segment scan decoder (glyphs, FSM states, digit count).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package codificador_siete_segmentos_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g, 0 = lit.
    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b1100000;
    localparam logic [6:0] GLYPH_C     = 7'b0110001;
    localparam logic [6:0] GLYPH_D     = 7'b1000010;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_F     = 7'b0111000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef logic [1:0] estado_t;
    localparam estado_t ST_IDLE  = 2'd0;
    localparam estado_t ST_TRACK = 2'd1;
    localparam estado_t ST_HELD  = 2'd2;

endpackage

// File: rtl/codificador_siete_segmentos_patron.sv
// Purpose : maps one active-low seven-segment glyph back to its hex nibble.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports   : seg_n_i glyph in; nibble_o decoded value (0 if unknown); err_o unknown-glyph flag.
module patron_a_hexadecimal
    import codificador_siete_segmentos_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] nibble_o,
    output logic       err_o
);

    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b0;
        case (seg_n_i)
            GLYPH_0: nibble_o = 4'h0;
            GLYPH_1: nibble_o = 4'h1;
            GLYPH_2: nibble_o = 4'h2;
            GLYPH_3: nibble_o = 4'h3;
            GLYPH_4: nibble_o = 4'h4;
            GLYPH_5: nibble_o = 4'h5;
            GLYPH_6: nibble_o = 4'h6;
            GLYPH_7: nibble_o = 4'h7;
            GLYPH_8: nibble_o = 4'h8;
            GLYPH_9: nibble_o = 4'h9;
            GLYPH_A: nibble_o = 4'hA;
            GLYPH_B: nibble_o = 4'hB;
            GLYPH_C: nibble_o = 4'hC;
            GLYPH_D: nibble_o = 4'hD;
            GLYPH_E: nibble_o = 4'hE;
            GLYPH_F: nibble_o = 4'hF;
            default: err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/codificador_siete_segmentos.sv
// Purpose : recovers the 4-digit hex value shown on a scanned, active-low seven-segment display.
// Latency : value updates STABLE_CYCLES edges after the first sample of the frame-completing digit.
// Backpressure: none; value_valid/value_err are single-cycle pulses, value holds between frames.
// Ports   : clk, rst (sync, active-high); seg_n/dig_n sampled display lines;
//           value 16-bit frame, value_valid update pulse, value_err unknown-glyph flag.
module codificador_siete_segmentos
    import codificador_siete_segmentos_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_n,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        value_err
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    estado_t     state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [6:0]  prev_seg_q;
    logic [3:0]  prev_dig_q;
    logic [15:0] buf_q, buf_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] value_q;
    logic        valid_q;
    logic        verr_q;

    logic [3:0]  dec_nib;
    logic        dec_err;
    logic        sel_vld;
    logic [1:0]  sel_idx;
    logic        same;
    logic [7:0]  count_inc;
    logic        capture;
    logic        frame_done;

    patron_a_hexadecimal u_patron (
        .seg_n_i  (seg_n),
        .nibble_o (dec_nib),
        .err_o    (dec_err)
    );

    // Exactly one select low identifies a digit; blanking and multi-select do not.
    always_comb begin
        sel_vld = 1'b1;
        sel_idx = 2'd0;
        case (dig_n)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_vld = 1'b0;
        endcase
    end

    assign same      = (seg_n == prev_seg_q) && (dig_n == prev_dig_q);
    assign count_inc = count_q + 8'd1;
    // HELD never recaptures, so a long-held digit contributes exactly once.
    assign capture   = sel_vld && same && (state_q != ST_HELD) && (count_inc == STABLE_CNT);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!sel_vld) begin
            state_d = ST_IDLE;
            count_d = 8'd0;
        end else if (!same) begin
            state_d = ST_TRACK;
            count_d = 8'd1;
        end else if (state_q != ST_HELD) begin
            count_d = count_inc;
            state_d = capture ? ST_HELD : ST_TRACK;
        end
    end

    // Buffer view including this edge's capture, so a completing frame loads its last digit.
    always_comb begin
        buf_d  = buf_q;
        err_d  = err_q;
        mask_d = mask_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && (sel_idx == 2'(i))) begin
                buf_d[4*i +: 4] = dec_nib;
                err_d[i]        = dec_err;
                mask_d[i]       = 1'b1;
            end
        end
    end

    assign frame_done = capture && (mask_d == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= 8'd0;
            prev_seg_q <= GLYPH_BLANK;
            prev_dig_q <= 4'hF;
            buf_q      <= 16'h0000;
            err_q      <= 4'h0;
            mask_q     <= 4'h0;
            value_q    <= 16'h0000;
            valid_q    <= 1'b0;
            verr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prev_seg_q <= seg_n;
            prev_dig_q <= dig_n;
            buf_q      <= buf_d;
            err_q      <= err_d;
            mask_q     <= frame_done ? 4'h0 : mask_d;
            valid_q    <= frame_done;
            verr_q     <= frame_done && (|err_d);
            if (frame_done) begin
                value_q <= buf_d;
            end
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign value_err   = verr_q;

endmodule

// File: tb/tb_codificador_siete_segmentos.sv
// Purpose : directed-vector bench for codificador_siete_segmentos.
// Latency : inputs change on the falling edge; outputs are read on the falling edge.
// Backpressure: n/a.
module tb_codificador_siete_segmentos;

    localparam logic [6:0] GL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BAD = 7'b1111110;
    localparam logic [6:0] BLK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic [15:0] value;
    logic        value_valid;
    logic        value_err;

    int   n_vec  = 0;
    int   n_bad  = 0;
    int   pulses = 0;
    logic last_err = 1'b0;

    always #5 clk = ~clk;

    codificador_siete_segmentos #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .value       (value),
        .value_valid (value_valid),
        .value_err   (value_err)
    );

    always @(negedge clk) begin
        if (value_valid) begin
            pulses   = pulses + 1;
            last_err = value_err;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a falling edge; n rising edges sample the pair.
    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_n = d;
        seg_n = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int idx, input logic [6:0] s, input int n);
        logic [3:0] d;
        d = ~(4'b0001 << idx);
        hold(d, s, n);
    endtask

    // Digits 0..3 for 4 samples each; the pulse must land right after the last one.
    task automatic frame(input logic [6:0] g0, input logic [6:0] g1,
                         input logic [6:0] g2, input logic [6:0] g3, input string tag);
        digit(0, g0, 4);
        digit(1, g1, 4);
        digit(2, g2, 4);
        check_vec({tag, "_early"}, 32'(value_valid), 32'd0);
        digit(3, g3, 4);
        check_vec({tag, "_lat"}, 32'(value_valid), 32'd1);
    endtask

    initial begin
        int p0;
        rst   = 1'b1;
        seg_n = BLK;
        dig_n = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_vec("rst_value", 32'(value), 32'h0);
        check_vec("rst_valid", 32'(value_valid), 32'd0);
        check_vec("rst_err", 32'(value_err), 32'd0);

        // Basic frame: 3,7,A,F.
        p0 = pulses;
        frame(GL[3], GL[7], GL[10], GL[15], "basic");
        check_vec("basic_err_pulse", 32'(value_err), 32'd0);
        hold(4'hF, BLK, 2);
        check_vec("basic_value", 32'(value), 32'hFA73);
        check_vec("basic_pulses", 32'(pulses - p0), 32'd1);
        check_vec("basic_valid_drop", 32'(value_valid), 32'd0);

        // Illegal glyph on digit 2.
        p0 = pulses;
        frame(GL[1], GL[2], BAD, GL[9], "illegal");
        check_vec("illegal_err_pulse", 32'(value_err), 32'd1);
        hold(4'hF, BLK, 2);
        check_vec("illegal_value", 32'(value), 32'h9021);
        check_vec("illegal_err_drop", 32'(value_err), 32'd0);
        check_vec("illegal_pulses", 32'(pulses - p0), 32'd1);

        // Digit 0 shown only 3 samples: frame must stay incomplete.
        p0 = pulses;
        digit(0, GL[5], 3);
        digit(1, GL[5], 4);
        digit(2, GL[5], 4);
        digit(3, GL[5], 4);
        hold(4'hF, BLK, 2);
        check_vec("short_pulses", 32'(pulses - p0), 32'd0);
        check_vec("short_value_hold", 32'(value), 32'h9021);
        digit(0, GL[5], 4);
        check_vec("short_complete_lat", 32'(value_valid), 32'd1);
        hold(4'hF, BLK, 2);
        check_vec("short_complete_value", 32'(value), 32'h5555);

        // Multi-select and blanking split a digit's dwell; the count must restart.
        p0 = pulses;
        digit(0, GL[6], 2);
        hold(4'b1100, GL[6], 1);
        digit(0, GL[6], 2);
        hold(4'hF, BLK, 1);
        digit(0, GL[6], 2);
        digit(1, GL[11], 4);
        hold(4'hF, BLK, 1);
        digit(2, GL[12], 4);
        hold(4'b0000, GL[8], 1);
        digit(3, GL[13], 4);
        hold(4'hF, BLK, 2);
        check_vec("idle_no_pulse", 32'(pulses - p0), 32'd0);
        digit(0, GL[14], 4);
        hold(4'hF, BLK, 2);
        check_vec("idle_value", 32'(value), 32'hDCBE);
        check_vec("idle_pulses", 32'(pulses - p0), 32'd1);

        // Latest capture of a digit wins.
        frame(GL[6], GL[3], GL[4], GL[5], "dummy");
        hold(4'hF, BLK, 2);
        digit(0, GL[6], 4);
        digit(0, GL[2], 4);
        digit(1, GL[3], 4);
        digit(2, GL[4], 4);
        digit(3, GL[5], 4);
        hold(4'hF, BLK, 2);
        check_vec("latest_value", 32'(value), 32'h5432);

        // Reset after three captures discards them.
        digit(1, GL[1], 4);
        digit(2, GL[2], 4);
        digit(3, GL[3], 4);
        rst = 1'b1;
        hold(4'hF, BLK, 2);
        rst = 1'b0;
        p0 = pulses;
        check_vec("midrst_value", 32'(value), 32'h0);
        digit(0, GL[7], 4);
        hold(4'hF, BLK, 2);
        check_vec("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        digit(1, GL[8], 4);
        digit(2, GL[9], 4);
        digit(3, GL[10], 4);
        hold(4'hF, BLK, 2);
        check_vec("midrst_value2", 32'(value), 32'hA987);
        check_vec("midrst_pulses", 32'(pulses - p0), 32'd1);

        // Long holds: one capture per digit, one pulse per frame.
        p0 = pulses;
        digit(0, GL[0], 20);
        digit(1, GL[1], 4);
        digit(2, GL[2], 4);
        digit(3, GL[3], 20);
        hold(4'hF, BLK, 10);
        check_vec("long_value", 32'(value), 32'h3210);
        check_vec("long_pulses", 32'(pulses - p0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/codificador_siete_segmentos.md
CODIFICADOR_SIETE_SEGMENTOS -- requirements
Module: codificador_siete_segmentos

Interface
REQ-001 The parameter STABLE_CYCLES SHALL default to 4 and set the consecutive identical samples required before a digit is captured; legal range is 2..255.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and be the reset; it is synchronous and active-high.
REQ-004 Port seg_n SHALL be an input, 7 bits wide, carrying active-low segments {a,b,c,d,e,f,g} on bits 6..0, where 0 means lit.
REQ-005 Port dig_n SHALL be an input, 4 bits wide, carrying active-low scanned digit selects; dig_n[i]=0 selects digit i.
REQ-006 Port value SHALL be an output, 16 bits wide, holding the last complete frame; digit i occupies value[4i+3:4i].
REQ-007 Port value_valid SHALL be an output, 1 bit wide, giving a one-cycle pulse when value is updated.
REQ-008 Port value_err SHALL be an output, 1 bit wide, set with value_valid when any digit of that frame held an unrecognised pattern.

Function
REQ-009 The block SHALL invert the display decoder: it maps a 7-bit active-low glyph back to a hex nibble.
- Glyph table: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
- Glyph table, continued: 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-010 A pattern not in the table SHALL decode to nibble 0 and set that digit's error bit.
REQ-011 A sample SHALL be the pair (seg_n, dig_n) taken at each rising clk edge; inputs are treated as synchronous.
REQ-012 The FSM SHALL have three states: IDLE, TRACK and HELD.
REQ-013 In IDLE, dig_n is not one-hot-low, including 1111 (blanking) and multi-select; the stability counter SHALL be 0.
REQ-014 In any state, a one-hot-low sample that differs from the previous sample SHALL cause a transition to TRACK with count=1.
REQ-015 In any state, a non-one-hot sample SHALL cause a transition to IDLE with count=0.
REQ-016 In TRACK, an identical sample SHALL increment count; when count reaches STABLE_CYCLES the digit is captured on that edge and the state moves to HELD.
REQ-017 Capture SHALL write the decoded nibble and error bit into slot i of a frame buffer and set mask[i].
REQ-018 In HELD, identical samples SHALL be ignored and no recapture occurs; count saturates.
REQ-019 Recapturing a digit already in the mask SHALL overwrite its slot (latest wins).
REQ-020 On the edge where mask becomes 1111, value SHALL load the buffer including the slot captured on that edge.
- On that edge, value_err is set to the OR of the four error bits.
- On that edge, mask is cleared.
- value_valid SHALL be high during the following cycle only.
REQ-021 Latency SHALL be exactly STABLE_CYCLES edges from the first sample of the completing digit to the value update.
REQ-022 value SHALL hold between frames; value_err SHALL be a pulse aligned with value_valid.
REQ-023 Frames SHALL be assembled in any digit order; no ordering check is performed.

Reset
REQ-024 While rst=1 at an edge, the block SHALL clear value=0, value_valid=0, value_err=0, mask=0, the frame buffer and count, set state=IDLE, and clear the previous-sample register to seg_n=1111111, dig_n=1111.
REQ-025 A reset mid-frame SHALL discard the partial frame; the first post-reset sample is treated as a change.

Structure
REQ-026 A shared package SHALL hold:
- the 16 glyph constants;
- the blank glyph 1111111;
- the FSM state typedef;
- the digit count (4).
REQ-027 One combinational sub-module, patron_a_hexadecimal, SHALL map seg_n to {err, nibble[3:0]}; the top holds the FSM, counter, buffer and mask.

Verification
REQ-028 After reset, hold dig_n=1110 with glyph 3, then 1101/7, 1011/A, 0111/F, each for 4 cycles -> value=16'hFA73, value_valid a single pulse, value_err=0.
REQ-029 Digit 2 shows glyph 1111110 (illegal) within an otherwise valid frame -> value[11:8]=0, value_err=1 on the pulse.
REQ-030 Hold dig_n=1110 glyph 5 for only 3 cycles, then change -> no capture, mask unchanged, no pulse.
REQ-031 Apply dig_n=1100 (two selects) and dig_n=1111 between digits -> IDLE and count reset; a subsequent valid frame still assembles correctly.
REQ-032 Assert rst after 3 of 4 digits are captured -> no pulse; the next full frame alone produces value_valid.
REQ-033 Hold a digit for 20 cycles, then complete the frame -> exactly one pulse per frame, with no duplicate capture effects.
